// File: rtl/datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : datapath_pkg                                           |
// | Description : Shared datapath types for the fetch front end.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package datapath_pkg;

  typedef logic [31:0] word_t;

  // Record presented to the scoreboard each cycle
  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t instr;
  } fetch_t;

  // One buffered instruction
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fq_entry_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : isa_pkg                                                |
// | Description : Instruction-set constants shared by the front end.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package isa_pkg;

  // Encoding that stops the fetch unit once it has been enqueued
  localparam logic [31:0] HALT_ENC = 32'hFFFF_FFFF;

endpackage : isa_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_fifo                                             |
// | Description : Circular buffer of fetched instructions with push,     |
// |               pop, synchronous clear and a head-entry output.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_fifo
  import datapath_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_clear,
  input  logic             i_push,
  input  fq_entry_t        i_data,
  input  logic             i_pop,
  output fq_entry_t        o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  fq_entry_t        mem_q [DEPTH];
  fq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (count_q == '0);
  assign o_full    = (count_q == C_DEPTH);
  assign o_count   = count_q;
  assign o_head    = mem_q[head_q];
  // A full buffer still accepts a push when the head leaves in the same cycle
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Next pointers, occupancy and storage; clear overrides any push or pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (i_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_do_push) begin
        mem_d[tail_q] = i_data;
        tail_d        = tail_q + 1'b1;
      end
      if (w_do_pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Buffer state registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_queue_unit                                       |
// | Description : Front-end fetch stage. Owns the PC, issues one         |
// |               instruction-memory read at a time, buffers responses   |
// |               and presents them to the scoreboard. Static not-taken: |
// |               PC advances by 4; redirects on flush.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_queue_unit
  import datapath_pkg::*;
  import isa_pkg::*;
#(
  parameter int unsigned FQ_DEPTH   = 4,
  parameter word_t       RESET_PC   = 32'h0000_0000,
  parameter word_t       HALT_INSTR = HALT_ENC
) (
  input  logic   CLK,
  input  logic   nRST,
  output logic   imem_ren,
  output word_t  imem_addr,
  input  logic   imem_hit,
  input  word_t  imem_rdata,
  input  logic   freeze,
  input  logic   flush,
  input  word_t  redirect_pc,
  output fetch_t fetch,
  output logic   halted
);

  localparam int unsigned      CNT_W   = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FQ_DEPTH);

  fetch_state_t     state_q, state_d;
  word_t            pc_q, pc_d;
  logic             ren_q, ren_d;
  word_t            addr_q, addr_d;
  logic             halted_q, halted_d;

  logic             w_push;
  logic             w_pop;
  logic             w_clear;
  logic             w_waiting;
  logic [CNT_W-1:0] w_count_nxt;
  fq_entry_t        w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_data  ('{pc: pc_q, instr: imem_rdata}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop     = !w_empty && !freeze;
  // A request is in flight and its response has not arrived this cycle
  assign w_waiting = ren_q && !imem_hit;

  // Next-state for the fetch FSM, PC and the registered memory request
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ren_d       = ren_q;
    addr_d      = addr_q;
    halted_d    = halted_q;
    w_push      = 1'b0;
    w_clear     = 1'b0;
    w_count_nxt = w_count;
    if (flush) begin
      // Queue is dropped; an unanswered request must still be retired
      w_clear  = 1'b1;
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      if (w_waiting) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
        ren_d   = 1'b0;
        addr_d  = redirect_pc;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (ren_q && imem_hit) begin
            w_push = !w_full || w_pop;
            pc_d   = pc_q + 32'd4;
            if (imem_rdata == HALT_INSTR) begin
              state_d  = HALT;
              halted_d = 1'b1;
              ren_d    = 1'b0;
              addr_d   = pc_q + 32'd4;
            end
          end
          w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
          // New request only if its response is guaranteed a free slot
          if (state_d == FETCH && !w_waiting) begin
            ren_d  = (w_count_nxt < C_DEPTH);
            addr_d = pc_d;
          end
        end
        DRAIN: begin
          // Stale response is discarded; fetch restarts at the redirected PC
          if (imem_hit) begin
            state_d = FETCH;
            ren_d   = 1'b0;
            addr_d  = pc_q;
          end
        end
        HALT: begin
          ren_d = 1'b0;
        end
        default: begin
          state_d = FETCH;
          ren_d   = 1'b0;
        end
      endcase
    end
  end

  // Fetch FSM, PC and registered request outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ren_q    <= 1'b0;
      addr_q   <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ren_q    <= ren_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
    end
  end

  // Head of queue straight to the scoreboard, zeroed when empty
  always_comb begin
    fetch = '0;
    if (!w_empty) begin
      fetch = '{valid: 1'b1, pc: w_head.pc, instr: w_head.instr};
    end
  end

  assign imem_ren  = ren_q;
  assign imem_addr = addr_q;
  assign halted    = halted_q;

endmodule : fetch_queue_unit
`default_nettype wire
